// File: rtl/io_pkg.sv
// Shared I/O window constants for the memory-mapped peripherals.
// Timer control/status bit positions live here too.
package io_pkg;
  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;
  localparam logic [31:0] ADDR_TCNT = 32'hF000_0020;
  localparam logic [31:0] ADDR_TLIM = 32'hF000_0024;
  localparam logic [31:0] ADDR_TCTL = 32'hF000_0028;

  localparam int TCTL_READY = 0;
  localparam int TCTL_IE    = 1;
  localparam int TCTL_OVR   = 2;
endpackage

// File: rtl/io_timer_if.sv
// Data-memory stage to timer bus: address, store strobe/data,
// and the read data, hit and interrupt returned by the timer.
interface io_timer_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             wrtEn;
  logic [DBITS-1:0] dIn;
  logic [DBITS-1:0] dOut;
  logic             hit;
  logic             irq;

  modport master (
    output addr, wrtEn, dIn,
    input  dOut, hit, irq
  );

  modport slave (
    input  addr, wrtEn, dIn,
    output dOut, hit, irq
  );
endinterface

// File: rtl/io_timer_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks.
// clr restarts the count so the next tick is CLK_DIV cycles away.
module tick_gen #(
  parameter int CLK_DIV = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] pre;

  assign tick = (pre == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clr || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + W'(1);
    end
  end
endmodule

// File: rtl/io_timer.sv
// Interval timer on the I/O window: TCNT counts prescaled ticks,
// wraps at TLIM and raises a sticky ready flag with overrun.
module io_timer
  import io_pkg::*;
#(
  parameter int               DBITS     = 32,
  parameter int               CLK_DIV   = 10000,
  parameter logic [DBITS-1:0] ADDR_TCNT = io_pkg::ADDR_TCNT,
  parameter logic [DBITS-1:0] ADDR_TLIM = io_pkg::ADDR_TLIM,
  parameter logic [DBITS-1:0] ADDR_TCTL = io_pkg::ADDR_TCTL
) (
  input  logic     clk,
  input  logic     reset,
  io_timer_if.slave bus
);
  logic [DBITS-1:0] tcnt;
  logic [DBITS-1:0] tlim;
  logic             ready;
  logic             ie;
  logic             ovr;
  logic             tick;

  logic hit_cnt, hit_lim, hit_ctl;
  logic wr_cnt, wr_lim, wr_ctl;
  logic wrap, clr_rdy, clr_ovr, set_ovr;

  assign hit_cnt = (bus.addr == ADDR_TCNT);
  assign hit_lim = (bus.addr == ADDR_TLIM);
  assign hit_ctl = (bus.addr == ADDR_TCTL);
  assign bus.hit = hit_cnt | hit_lim | hit_ctl;

  assign wr_cnt = bus.wrtEn & hit_cnt;
  assign wr_lim = bus.wrtEn & hit_lim;
  assign wr_ctl = bus.wrtEn & hit_ctl;

  assign clr_rdy = wr_ctl & ~bus.dIn[TCTL_READY];
  assign clr_ovr = wr_ctl & ~bus.dIn[TCTL_OVR];

  // A TCNT store swallows a coincident tick, wrap included.
  assign wrap = tick & ~wr_cnt & (tlim != '0)
              & (tcnt >= tlim - DBITS'(1));
  // Acknowledging ready in the wrap cycle consumes the old event.
  assign set_ovr = wrap & ready & ~clr_rdy;

  assign bus.irq = ready & ie;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (wr_cnt),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      tlim  <= '0;
      ready <= 1'b0;
      ie    <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (wr_cnt) begin
        tcnt <= bus.dIn;
      end else if (wrap) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + DBITS'(1);
      end

      if (wr_lim) tlim <= bus.dIn;
      if (wr_ctl) ie <= bus.dIn[TCTL_IE];

      if (wrap) begin
        ready <= 1'b1;
      end else if (clr_rdy) begin
        ready <= 1'b0;
      end

      if (set_ovr) begin
        ovr <= 1'b1;
      end else if (clr_ovr) begin
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.dOut = '0;
    unique case (1'b1)
      hit_cnt: bus.dOut = tcnt;
      hit_lim: bus.dOut = tlim;
      hit_ctl: begin
        bus.dOut[TCTL_READY] = ready;
        bus.dOut[TCTL_IE]    = ie;
        bus.dOut[TCTL_OVR]   = ovr;
      end
      default: bus.dOut = '0;
    endcase
  end
endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer with a 4-cycle prescaler.
// Expected values are hand-derived from the register behaviour.
module tb_io_timer;
  import io_pkg::*;

  localparam logic [31:0] ADDR_BAD = 32'hF000_002C;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  io_timer_if #(.DBITS(32)) bus ();

  io_timer #(
    .DBITS  (32),
    .CLK_DIV(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.wrtEn = 1'b0;
    #1;
    d = bus.dOut;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.dIn   = d;
    bus.wrtEn = 1'b1;
    @(posedge clk);
    #1;
    bus.wrtEn = 1'b0;
  endtask

  // Pulse reset away from the clock edge; next edge is prescale edge 1.
  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    bus.addr  = '0;
    bus.dIn   = '0;
    bus.wrtEn = 1'b0;
    reset     = 1'b1;
    step(2);
    do_reset();

    rd(ADDR_TCNT, v); check("rst_tcnt", v, 32'd0);
    check("rst_hit", {31'd0, bus.hit}, 32'd1);
    rd(ADDR_TLIM, v); check("rst_tlim", v, 32'd0);
    rd(ADDR_TCTL, v); check("rst_tctl", v, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);

    for (int i = 1; i <= 12; i++) begin
      step(1);
      rd(ADDR_TCNT, v);
      check($sformatf("free_%0d", i), v, 32'(i / 4));
    end
    rd(ADDR_TCTL, v); check("free_tctl", v, 32'd0);
    check("free_irq", {31'd0, bus.irq}, 32'd0);

    do_reset();
    step(1);
    wr(ADDR_TLIM, 32'd3);
    wr(ADDR_TCTL, 32'd2);
    wr(ADDR_TCNT, 32'd0);
    step(4); rd(ADDR_TCNT, v); check("wrap_c1", v, 32'd1);
    step(4); rd(ADDR_TCNT, v); check("wrap_c2", v, 32'd2);
    step(3); rd(ADDR_TCTL, v); check("wrap_pre", v, 32'd2);
    check("wrap_irq0", {31'd0, bus.irq}, 32'd0);
    step(1); rd(ADDR_TCNT, v); check("wrap_c0", v, 32'd0);
    rd(ADDR_TCTL, v); check("wrap_rdy", v, 32'd3);
    check("wrap_irq1", {31'd0, bus.irq}, 32'd1);
    step(12); rd(ADDR_TCTL, v); check("ovr_set", v, 32'd7);

    wr(ADDR_TCTL, 32'd2);
    rd(ADDR_TCTL, v); check("clr_notick", v, 32'd2);
    step(11); rd(ADDR_TCTL, v); check("rdy_again", v, 32'd3);
    step(11);
    wr(ADDR_TCTL, 32'd2);
    rd(ADDR_TCTL, v); check("set_wins", v, 32'd3);

    do_reset();
    step(1);
    wr(ADDR_TCNT, 32'hFFFF_FFFF);
    step(3); rd(ADDR_TCNT, v); check("max_hold", v, 32'hFFFF_FFFF);
    step(1); rd(ADDR_TCNT, v); check("max_wrap", v, 32'd0);
    rd(ADDR_TCTL, v); check("max_rdy0", v, 32'd0);
    step(3);
    wr(ADDR_TCNT, 32'd5);
    rd(ADDR_TCNT, v); check("ld_tick", v, 32'd5);
    step(3); rd(ADDR_TCNT, v); check("ld_hold", v, 32'd5);
    step(1); rd(ADDR_TCNT, v); check("ld_inc", v, 32'd6);

    do_reset();
    step(1);
    wr(ADDR_TCNT, 32'd10);
    wr(ADDR_TLIM, 32'd4);
    step(2); rd(ADDR_TCNT, v); check("low_pre", v, 32'd10);
    step(1); rd(ADDR_TCNT, v); check("low_wrap", v, 32'd0);
    rd(ADDR_TCTL, v); check("low_rdy", v, 32'd1);
    rd(ADDR_BAD, v); check("bad_dout", v, 32'd0);
    check("bad_hit", {31'd0, bus.hit}, 32'd0);
    wr(ADDR_BAD, 32'h1234_5678);
    rd(ADDR_TCNT, v); check("bad_tcnt", v, 32'd0);
    rd(ADDR_TLIM, v); check("bad_tlim", v, 32'd4);
    rd(ADDR_TCTL, v); check("bad_tctl", v, 32'd1);

    do_reset();
    step(1);
    wr(ADDR_TCTL, 32'd2);
    wr(ADDR_TLIM, 32'd1);
    wr(ADDR_TCNT, 32'd0);
    step(8);
    wr(ADDR_TLIM, 32'd0);
    wr(ADDR_TCNT, 32'd7);
    rd(ADDR_TCNT, v); check("ar_tcnt7", v, 32'd7);
    rd(ADDR_TCTL, v); check("ar_tctl7", v, 32'd7);
    check("ar_irq1", {31'd0, bus.irq}, 32'd1);
    reset = 1'b1;
    #1;
    rd(ADDR_TCNT, v); check("ar_tcnt", v, 32'd0);
    rd(ADDR_TLIM, v); check("ar_tlim", v, 32'd0);
    rd(ADDR_TCTL, v); check("ar_tctl", v, 32'd0);
    check("ar_irq", {31'd0, bus.irq}, 32'd0);
    reset = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped interval timer peripheral that responds to processor loads and stores in the I/O window at 0xF0000020–0xF0000028, alongside the KEY/SW/HEX/LEDR/LEDG devices. It counts prescaled clock ticks, wraps at a programmable limit and raises a sticky ready flag with overrun detection. The data-memory stage forwards the memory-stage address, write enable and store data to it, and selects its read data when `hit` is high.

## Interface
- `DBITS`, 32: bus data/address width.
- `CLK_DIV`, 10000: clk cycles per counter tick; legal range 1..2^16.
- `ADDR_TCNT`, 32'hF0000020: counter register address.
- `ADDR_TLIM`, 32'hF0000024: limit register address.
- `ADDR_TCTL`, 32'hF0000028: control/status register address.

- `clk`  in  1  processor clock.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  DBITS  memory-stage address (aluOut_m).
- `wrtEn`  in  1  store strobe (memWrite_m).
- `dIn`  in  DBITS  store data (sr2Out_m).
- `dOut`  out  DBITS  read data; 0 when `hit`=0.
- `hit`  out  1  `addr` matches one of the three registers.
- `irq`  out  1  `ready & ie`.

## Operation
- TCNT: R/W, 32-bit up-counter.
- TLIM: R/W. A value of 0 disables wrap, and TCNT free-runs modulo 2^32.
- TCTL: bit0 `ready` (R, write-0-to-clear), bit1 `ie` (R/W), bit2 `overrun` (R, write-0-to-clear). Bits 31:3 read 0 and ignore writes. Writing 1 to bit0 or bit2 leaves the bit unchanged.
- Prescaler counts 0..CLK_DIV-1. The `tick` pulse is 1 cycle, at prescaler == CLK_DIV-1, and the prescaler then returns to 0.
- On `tick` with TLIM≠0 and TCNT ≥ TLIM-1:
  - TCNT ← 0;
  - `ready` ← 1;
  - if `ready` was already 1, `overrun` ← 1.
- On `tick` otherwise: TCNT ← TCNT+1, wrapping 0xFFFFFFFF→0.
- The ≥ compare guarantees wrap within one tick after TLIM is lowered below TCNT.
- Write to TCNT loads `dIn` and clears the prescaler to 0. The write beats a simultaneous tick.
- Write to TLIM loads `dIn`; TCNT and the prescaler are unaffected.
- Write to TCTL clearing `ready` or `overrun` in the same cycle the hardware sets it: the set wins, so no event is lost. `ie` always takes the written value.
- Writes with `hit`=0 are ignored. Addresses are full 32-bit compares, with no aliasing.

## Timing
- Reads are combinational: `dOut`/`hit` valid in the same cycle as `addr`, matching the data-memory read path.
- A read in the cycle of a write to the same register returns the old value.
- Writes and counter updates take effect at the rising edge of `clk`.
- `ready` is visible 1 cycle after the wrapping tick. `irq` is registered-from-state, so it has no extra latency beyond `ready`.
- On `reset`: TCNT=0, TLIM=0, TCTL=0, prescaler=0. Resulting outputs: `irq`=0, `hit` and `dOut` per `addr` (reads of TCNT, TLIM and TCTL return 0).
- Reset asserted mid-count clears all state immediately, without waiting for a clock edge. The first tick occurs CLK_DIV cycles after reset deasserts.

## Structure
- Shared package `io_pkg`:
  - the I/O address constants (KEY, SW, HEX, LEDR, LEDG, TCNT, TLIM, TCTL);
  - TCTL bit indices `TCTL_READY`=0, `TCTL_IE`=1, `TCTL_OVR`=2.
- One sub-module, `tick_gen`:
  - prescaler parameterised by CLK_DIV;
  - inputs `clk`, `reset`, `clr`; output `tick`.
- The register file, compare, flag logic and read mux stay in `io_timer`.

## Test plan
All scenarios use CLK_DIV=4.
- Reset, then free-run with TLIM=0 → TCNT reads 0 for 4 cycles, then 1, 2, 3 at 4-cycle spacing. `ready`=0, `irq`=0.
- Write TLIM=3, TCTL=0x2 → TCNT sequence 0,1,2,0. `ready`=1 one cycle after the wrap tick; `irq`=1. A second wrap without clearing sets TCTL=0x7.
- With `ready`=1, write TCTL=0x2 on the exact cycle of a wrap tick → TCTL reads 0x3 afterwards, so the set wins. A write on a non-tick cycle gives 0x2.
- Write TCNT=0xFFFFFFFF with TLIM=0 → after 4 cycles TCNT=0 and `ready` stays 0. Issue a TCNT write on a tick cycle with `dIn`=5 → TCNT=5, and the next increment comes 4 cycles later.
- With TCNT=10, write TLIM=4 → the next tick wraps TCNT to 0 and sets `ready`. Read of 0xF000002C → `hit`=0, `dOut`=0. Write to 0xF000002C changes no register.
- Assert `reset` asynchronously mid-count with TCNT=7 and TCTL=0x7 → all registers and `irq` read 0 before the next clock edge.
